// File: rtl/branch_scanner.sv
// branch_scanner: resolves CBF/CBB targets by walking program memory one opcode per fetch (optional target cache: BRANCH_CACHE_EN).
// Latency: not-taken (or cache hit) -> done 1 cycle after start; taken -> one cycle per scanned opcode plus memory wait, then done.
// Backpressure: each read holds scan_req/scan_addr until instr_valid; busy stalls the core while scanning or faulted.

package branch_scanner_pkg;
  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_INC   = 4'd1,
    OP_DEC   = 4'd2,
    OP_LEFT  = 4'd3,
    OP_RIGHT = 4'd4,
    OP_OUT   = 4'd5,
    OP_IN    = 4'd6,
    OP_CBF   = 4'd7,
    OP_CBB   = 4'd8
  } op_code;
endpackage

module branch_scanner
  import branch_scanner_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DEPTH_W       = 8,
  parameter int CACHE_ENTRIES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               is_backward,
  input  logic               acc_zero,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               scan_req,
  output logic [ADDR_W-1:0]  scan_addr,
  input  logic               instr_valid,
  input  op_code             instr,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  target_pc,
  output logic [DEPTH_W-1:0] depth,
  output logic               fault
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE, S_FAULT} state_t;

  localparam logic [ADDR_W-1:0]  ADDR_MAX  = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   scan_addr_n, target_n;
  logic [DEPTH_W-1:0]  depth_n;
  logic                dir_q, dir_n;      // direction of the branch being resolved (1 = backward)
  logic                taken, is_same, is_opp, at_edge;
  logic                cache_hit;
  logic [ADDR_W-1:0]   cache_tgt;

  // Next-state, datapath updates and state-decoded outputs
  always_comb begin
    state_n     = state;
    scan_addr_n = scan_addr;
    target_n    = target_pc;
    depth_n     = depth;
    dir_n       = dir_q;
    scan_req    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    fault       = 1'b0;
    taken       = is_backward ^ acc_zero;
    is_same     = (instr == (dir_q ? OP_CBB : OP_CBF));
    is_opp      = (instr == (dir_q ? OP_CBF : OP_CBB));
    // the next step would leave the address space
    at_edge     = dir_q ? (scan_addr == '0) : (scan_addr == ADDR_MAX);

    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (!taken) begin
            target_n = pc_in + 1'b1;
            state_n  = S_DONE;
          end else if (cache_hit) begin
            target_n = cache_tgt;
            state_n  = S_DONE;
          end else begin
            depth_n = DEPTH_W'(1);
            dir_n   = is_backward;
            // the very first step from pc_in would already wrap
            if (is_backward ? (pc_in == '0) : (pc_in == ADDR_MAX)) begin
              state_n = S_FAULT;
            end else begin
              scan_addr_n = is_backward ? (pc_in - 1'b1) : (pc_in + 1'b1);
              state_n     = S_FETCH;
            end
          end
        end
      end
      S_FETCH: begin
        scan_req = 1'b1;
        busy     = 1'b1;
        if (instr_valid) begin
          // depth saturating is an error; depth keeps its last legal value
          if (is_same && (depth == DEPTH_MAX)) begin
            state_n = S_FAULT;
          end else begin
            depth_n = is_same ? (depth + 1'b1) : (is_opp ? (depth - 1'b1) : depth);
            if (depth_n == '0) begin
              target_n = scan_addr + 1'b1;
              state_n  = S_DONE;
            end else if (at_edge) begin
              state_n = S_FAULT;
            end else begin
              scan_addr_n = dir_q ? (scan_addr - 1'b1) : (scan_addr + 1'b1);
            end
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      S_FAULT: begin
        busy  = 1'b1;
        fault = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      scan_addr <= '0;
      target_pc <= '0;
      depth     <= '0;
      dir_q     <= 1'b0;
    end else begin
      state     <= state_n;
      scan_addr <= scan_addr_n;
      target_pc <= target_n;
      depth     <= depth_n;
      dir_q     <= dir_n;
    end
  end

`ifdef BRANCH_CACHE_EN
  localparam int IDX_W = (CACHE_ENTRIES > 1) ? $clog2(CACHE_ENTRIES) : 1;

  logic [CACHE_ENTRIES-1:0] c_vld;
  logic [CACHE_ENTRIES-1:0] c_dir;
  logic [ADDR_W-1:0]        c_pc  [CACHE_ENTRIES];
  logic [ADDR_W-1:0]        c_tgt [CACHE_ENTRIES];
  logic [IDX_W-1:0]         c_ptr;
  logic [ADDR_W-1:0]        orig_pc;
  logic                     alloc;

  // only a completed scan allocates; hits and not-taken branches never reach FETCH
  assign alloc = (state == S_FETCH) && (state_n == S_DONE);

  // Fully associative lookup on (pc_in, direction)
  always_comb begin
    cache_hit = 1'b0;
    cache_tgt = '0;
    for (int i = 0; i < CACHE_ENTRIES; i++) begin
      if (c_vld[i] && (c_pc[i] == pc_in) && (c_dir[i] == is_backward)) begin
        cache_hit = 1'b1;
        cache_tgt = c_tgt[i];
      end
    end
  end

  // Round-robin fill of resolved targets, keyed by the originating branch
  always_ff @(posedge clock) begin
    if (reset) begin
      c_vld   <= '0;
      c_ptr   <= '0;
      orig_pc <= '0;
    end else begin
      if ((state == S_IDLE) && start) orig_pc <= pc_in;
      if (alloc) begin
        c_vld[c_ptr] <= 1'b1;
        c_dir[c_ptr] <= dir_q;
        c_pc[c_ptr]  <= orig_pc;
        c_tgt[c_ptr] <= target_n;
        c_ptr        <= (c_ptr == IDX_W'(CACHE_ENTRIES - 1)) ? '0 : (c_ptr + 1'b1);
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_tgt = '0;
`endif

endmodule
